pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage RISC-V pipeline. It merges the

---
 rtl/pipeline_stall_ctrl.sv | 97 +++++++++
 tb/tb_pipeline_stall_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - prioritised stall/flush scheduler for the 5-stage pipeline
// Merges load-use, branch redirect, MUL/DIV and memory wait into per-stage controls.
module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use_hazard,
   input  logic             ex_branch_taken,
   input  logic             ex_muldiv_start,
   input  logic             muldiv_done,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             flush_mem,
   output logic             bus_fault,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0]  WAIT_MAX = WC_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_WAIT  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   state_t          state_q;
   logic            md_busy;
   logic [WC_W-1:0] wait_cnt;

   logic raw_mem, fault, mem_st, md_st;
   logic stall_ex_c, stall_id_c, flush_id_c, flush_ex_c, flush_mem_c;

   always_comb begin
      raw_mem     = mem_req & ~mem_ready;
      fault       = raw_mem & (wait_cnt == WAIT_MAX);
      mem_st      = raw_mem & ~fault;
      md_st       = (md_busy | ex_muldiv_start) & ~muldiv_done;
      stall_ex_c  = mem_st | md_st;
      stall_id_c  = stall_ex_c | (load_use_hazard & ~ex_branch_taken);
      flush_mem_c = md_st & ~mem_st;
      flush_id_c  = ex_branch_taken & ~stall_ex_c;
      flush_ex_c  = (ex_branch_taken | load_use_hazard) & ~stall_ex_c;
   end

   // Combinational controls are forced low while reset is held.
   assign stall_mem = mem_st & ~rst;
   assign stall_ex  = stall_ex_c & ~rst;
   assign stall_id  = stall_id_c & ~rst;
   assign stall_if  = stall_id_c & ~rst;
   assign flush_mem = flush_mem_c & ~rst;
   assign flush_id  = flush_id_c & ~rst;
   assign flush_ex  = flush_ex_c & ~rst;
   assign bus_fault = fault & ~rst;
   assign state     = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         md_busy      <= 1'b0;
         wait_cnt     <= '0;
         stall_cycles <= '0;
      end else begin
         if (mem_st)
            state_q <= ST_MEM_WAIT;
         else if (md_st)
            state_q <= ST_MD_WAIT;
         else
            state_q <= ST_RUN;

         if (muldiv_done)
            md_busy <= 1'b0;
         else if (ex_muldiv_start)
            md_busy <= 1'b1;

         // Restart the count after a fault so a persistent wait faults again.
         if (!raw_mem || fault)
            wait_cnt <= '0;
         else if (mem_st)
            wait_cnt <= wait_cnt + WC_W'(1);

         if (stall_id_c && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed-vector bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_use_hazard, ex_branch_taken, ex_muldiv_start;
   logic       muldiv_done, mem_req, mem_ready;
   logic       stall_if, stall_id, stall_ex, stall_mem;
   logic       flush_id, flush_ex, flush_mem, bus_fault;
   logic [1:0] state;
   logic [3:0] stall_cycles;
   logic [7:0] ctl;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [7:0] E_IDLE = 8'b0000_0000;
   localparam logic [7:0] E_LU   = 8'b1100_0100;
   localparam logic [7:0] E_MD   = 8'b1110_0010;
   localparam logic [7:0] E_MEM  = 8'b1111_0000;
   localparam logic [7:0] E_FLT  = 8'b0000_0001;
   localparam logic [7:0] E_BR   = 8'b0000_1100;

   pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .load_use_hazard (load_use_hazard),
      .ex_branch_taken (ex_branch_taken),
      .ex_muldiv_start (ex_muldiv_start),
      .muldiv_done     (muldiv_done),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .stall_ex        (stall_ex),
      .stall_mem       (stall_mem),
      .flush_id        (flush_id),
      .flush_ex        (flush_ex),
      .flush_mem       (flush_mem),
      .bus_fault       (bus_fault),
      .state           (state),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, bus_fault};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic lu, input logic br, input logic ms,
                         input logic md, input logic mr, input logic mry);
      load_use_hazard = lu;
      ex_branch_taken = br;
      ex_muldiv_start = ms;
      muldiv_done     = md;
      mem_req         = mr;
      mem_ready       = mry;
   endtask

   task automatic step(input logic [7:0] exp_ctl, input string tag);
      @(negedge clk);
      check(tag, 32'(ctl), 32'(exp_ctl));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1, 1, 1, 0, 1, 0);
      #2;
      check("rst_ctl", 32'(ctl), 32'(E_IDLE));
      check("rst_state", 32'(state), 0);
      check("rst_cnt", 32'(stall_cycles), 0);
      set_in(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: load-use bubble
      set_in(1, 0, 0, 0, 0, 0);
      step(E_LU, "t1_lu");
      check("t1_cnt", 32'(stall_cycles), 1);
      set_in(0, 0, 0, 0, 0, 0);
      step(E_IDLE, "t1_idle");

      // 2: 3-cycle muldiv
      set_in(0, 0, 1, 0, 0, 0);
      step(E_MD, "t2_md0");
      check("t2_state0", 32'(state), 1);
      set_in(0, 0, 0, 0, 0, 0);
      step(E_MD, "t2_md1");
      step(E_MD, "t2_md2");
      set_in(0, 0, 0, 1, 0, 0);
      step(E_IDLE, "t2_done");
      check("t2_state_run", 32'(state), 0);
      check("t2_cnt", 32'(stall_cycles), 4);
      set_in(0, 0, 1, 1, 0, 0);
      step(E_IDLE, "t2_1cyc");
      set_in(0, 0, 0, 0, 0, 0);
      step(E_IDLE, "t2_1cyc_nobusy");

      // 3: two memory wait cycles
      set_in(0, 0, 0, 0, 1, 0);
      step(E_MEM, "t3_w0");
      check("t3_state", 32'(state), 2);
      step(E_MEM, "t3_w1");
      set_in(0, 0, 0, 0, 1, 1);
      step(E_IDLE, "t3_ready");
      check("t3_state_run", 32'(state), 0);
      check("t3_cnt", 32'(stall_cycles), 6);

      // 4: watchdog expiry and restart
      set_in(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         step((i % 5 == 4) ? E_FLT : E_MEM, $sformatf("t4_c%0d", i));
      check("t4_cnt", 32'(stall_cycles), 14);
      set_in(0, 0, 0, 0, 0, 0);
      step(E_IDLE, "t4_idle");

      // Branch and load-use with no stall: branch wins
      set_in(1, 1, 0, 0, 0, 0);
      step(E_BR, "br_lu");

      // 5: mem stall over muldiv wait with branch held, counter saturation
      set_in(0, 1, 1, 0, 1, 0);
      step(E_MEM, "t5_both");
      check("t5_cnt_sat", 32'(stall_cycles), 15);
      set_in(0, 1, 0, 0, 1, 1);
      step(E_MD, "t5_md_only");
      check("t5_cnt_hold", 32'(stall_cycles), 15);
      set_in(0, 1, 0, 1, 0, 0);
      step(E_BR, "t5_release");
      set_in(0, 0, 0, 0, 0, 0);
      step(E_IDLE, "t5_idle");

      // 6: reset in the middle of a muldiv wait
      rst = 1'b1;
      #1;
      rst = 1'b0;
      check("t6_pre_cnt", 32'(stall_cycles), 0);
      set_in(0, 0, 1, 0, 0, 0);
      step(E_MD, "t6_md0");
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 7; i++)
         step(E_MD, $sformatf("t6_md%0d", i));
      check("t6_cnt7", 32'(stall_cycles), 7);
      check("t6_state1", 32'(state), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_ctl", 32'(ctl), 32'(E_IDLE));
      check("t6_rst_state", 32'(state), 0);
      check("t6_rst_cnt", 32'(stall_cycles), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(E_IDLE, "t6_after0");
      step(E_IDLE, "t6_after1");
      check("t6_after_state", 32'(state), 0);
      check("t6_after_cnt", 32'(stall_cycles), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
